// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM and its opcode classifier.
package multicycle_control_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      CL_RTYPE,
      CL_JR,
      CL_J,
      CL_JAL,
      CL_BEQ,
      CL_BNE,
      CL_IARITH,
      CL_LW,
      CL_SW,
      CL_ILLEGAL
   } instr_class_t;

   localparam logic [5:0] OP_RTYPE     = 6'h00;
   localparam logic [5:0] OP_J         = 6'h02;
   localparam logic [5:0] OP_JAL       = 6'h03;
   localparam logic [5:0] OP_BEQ       = 6'h04;
   localparam logic [5:0] OP_BNE       = 6'h05;
   localparam logic [5:0] OP_IARITH_LO = 6'h08;
   localparam logic [5:0] OP_IARITH_HI = 6'h0F;
   localparam logic [5:0] OP_LW        = 6'h23;
   localparam logic [5:0] OP_SW        = 6'h2B;
   localparam logic [5:0] FUNCT_JR     = 6'h08;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/memory inputs and datapath control outputs of the multicycle controller.
interface multicycle_control_if;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        mem_ready;
   logic        ir_write;
   logic        pc_write;
   logic        branch;
   logic        nbranch;
   logic        jmp;
   logic        jal;
   logic        jrn;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        illegal;
   logic        fault;
   logic [2:0]  state;
   logic [31:0] instr_count;

   modport master (
      output opcode, funct, mem_ready,
      input  ir_write, pc_write, branch, nbranch, jmp, jal, jrn,
      input  reg_write, mem_read, mem_write, illegal, fault, state, instr_count
   );

   modport slave (
      input  opcode, funct, mem_ready,
      output ir_write, pc_write, branch, nbranch, jmp, jal, jrn,
      output reg_write, mem_read, mem_write, illegal, fault, state, instr_count
   );
endinterface

// File: rtl/multicycle_control_opclass.sv
// Maps a captured opcode/funct pair onto the instruction class driving the FSM.
module multicycle_opclass
   import multicycle_control_pkg::*;
(
   input  logic [5:0]   opcode_i,
   input  logic [5:0]   funct_i,
   output instr_class_t class_o
);

   always_comb begin
      class_o = CL_ILLEGAL;
      case (opcode_i)
         OP_RTYPE: class_o = (funct_i == FUNCT_JR) ? CL_JR : CL_RTYPE;
         OP_J:     class_o = CL_J;
         OP_JAL:   class_o = CL_JAL;
         OP_BEQ:   class_o = CL_BEQ;
         OP_BNE:   class_o = CL_BNE;
         OP_LW:    class_o = CL_LW;
         OP_SW:    class_o = CL_SW;
         default: begin
            if (opcode_i >= OP_IARITH_LO && opcode_i <= OP_IARITH_HI) class_o = CL_IARITH;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM. Define MULTICYCLE_MEM_WAIT_EN to make FETCH/MEM
// wait on mem_ready with a WAIT_LIMIT timeout into a sticky FAULT state.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input logic                 clock,
   input logic                 reset,
   multicycle_control_if.slave bus
);

   state_t       state_q, state_d;
   logic [5:0]   op_q, op_d, funct_q, funct_d;
   logic [31:0]  count_q, count_d;
   instr_class_t cls;
   logic         mem_done, wait_expired;
   logic         ir_write_c, pc_write_c, branch_c, nbranch_c, jmp_c, jal_c, jrn_c;
   logic         reg_write_c, mem_read_c, mem_write_c, illegal_c;

   multicycle_opclass u_opclass (
      .opcode_i (op_q),
      .funct_i  (funct_q),
      .class_o  (cls)
   );

`ifdef MULTICYCLE_MEM_WAIT_EN
   localparam int WCW = $clog2(WAIT_LIMIT + 1);
   logic [WCW-1:0] wait_q, wait_d;

   assign mem_done     = bus.mem_ready;
   assign wait_expired = !bus.mem_ready && (wait_q == WCW'(WAIT_LIMIT - 1));
   // Counter only advances while parked in FETCH/MEM; any state change restarts it.
   assign wait_d = ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready &&
                    state_d == state_q) ? wait_q + 1'b1 : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) wait_q <= '0;
      else        wait_q <= wait_d;
   end

   assign bus.fault = (state_q == S_FAULT);
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign mem_done         = 1'b1;
   assign wait_expired     = 1'b0;
   assign bus.fault        = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         funct_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      funct_d     = funct_q;
      count_d     = count_q;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      branch_c    = 1'b0;
      nbranch_c   = 1'b0;
      jmp_c       = 1'b0;
      jal_c       = 1'b0;
      jrn_c       = 1'b0;
      reg_write_c = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      illegal_c   = 1'b0;

      case (state_q)
         S_FETCH: begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            mem_read_c = 1'b1;
            if (mem_done) begin
               op_d    = bus.opcode;
               funct_d = bus.funct;
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            if (cls == CL_ILLEGAL) begin
               illegal_c = 1'b1;
               state_d   = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls)
               CL_RTYPE, CL_IARITH: state_d = S_WB;
               CL_LW, CL_SW:        state_d = S_MEM;
               CL_JR:  begin jrn_c = 1'b1; pc_write_c = 1'b1; state_d = S_FETCH; end
               CL_J:   begin jmp_c = 1'b1; pc_write_c = 1'b1; state_d = S_FETCH; end
               CL_JAL: begin
                  jal_c       = 1'b1;
                  pc_write_c  = 1'b1;
                  reg_write_c = 1'b1;
                  state_d     = S_FETCH;
               end
               CL_BEQ: begin branch_c  = 1'b1; state_d = S_FETCH; end
               CL_BNE: begin nbranch_c = 1'b1; state_d = S_FETCH; end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (cls == CL_SW) mem_write_c = 1'b1;
            else              mem_read_c  = 1'b1;
            if (mem_done)          state_d = (cls == CL_LW) ? S_WB : S_FETCH;
            else if (wait_expired) state_d = S_FAULT;
         end
         S_WB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase

      // Only completed instructions retire; illegal opcodes leave from DECODE.
      if (state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
         count_d = count_q + 32'd1;
   end

   // Strobes are gated by reset so they drop the instant reset asserts.
   assign bus.ir_write    = ir_write_c  & reset;
   assign bus.pc_write    = pc_write_c  & reset;
   assign bus.branch      = branch_c    & reset;
   assign bus.nbranch     = nbranch_c   & reset;
   assign bus.jmp         = jmp_c       & reset;
   assign bus.jal         = jal_c       & reset;
   assign bus.jrn         = jrn_c       & reset;
   assign bus.reg_write   = reg_write_c & reset;
   assign bus.mem_read    = mem_read_c  & reset;
   assign bus.mem_write   = mem_write_c & reset;
   assign bus.illegal     = illegal_c   & reset;
   assign bus.state       = state_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_multicycle_control;

   logic clock = 1'b0;
   logic reset = 1'b0;

   multicycle_control_if bus ();

   multicycle_control #(.WAIT_LIMIT(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Strobe vector: {ir,pc,mr,mw,rw,br,nbr,jmp,jal,jrn,ill}
   localparam logic [10:0] M_IR  = 11'b100_0000_0000;
   localparam logic [10:0] M_PC  = 11'b010_0000_0000;
   localparam logic [10:0] M_MR  = 11'b001_0000_0000;
   localparam logic [10:0] M_MW  = 11'b000_1000_0000;
   localparam logic [10:0] M_RW  = 11'b000_0100_0000;
   localparam logic [10:0] M_BR  = 11'b000_0010_0000;
   localparam logic [10:0] M_NBR = 11'b000_0001_0000;
   localparam logic [10:0] M_JMP = 11'b000_0000_1000;
   localparam logic [10:0] M_JAL = 11'b000_0000_0100;
   localparam logic [10:0] M_JRN = 11'b000_0000_0010;
   localparam logic [10:0] M_ILL = 11'b000_0000_0001;
   localparam logic [10:0] M_F   = M_IR | M_PC | M_MR;

   typedef struct {
      logic [2:0]  st;
      logic [10:0] sb;
      logic        flt;
      logic [31:0] cnt;
      int          tag;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          tag = 0;
   logic [31:0] exp_count = 0;

   function automatic logic [10:0] strobes();
      return {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
              bus.branch, bus.nbranch, bus.jmp, bus.jal, bus.jrn, bus.illegal};
   endfunction

   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         logic [10:0] sb;
         e  = exp_q.pop_front();
         sb = strobes();
         checks++;
         if (bus.state !== e.st || sb !== e.sb || bus.fault !== e.flt || bus.instr_count !== e.cnt) begin
            failures++;
            $display("FAIL cycle[instr %0d] actual state=%0d strobes=%b fault=%b count=%0d required state=%0d strobes=%b fault=%b count=%0d",
                     e.tag, bus.state, sb, bus.fault, bus.instr_count, e.st, e.sb, e.flt, e.cnt);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [10:0] sb, input logic flt);
      exp_t e;
      e.st  = st;
      e.sb  = sb;
      e.flt = flt;
      e.cnt = exp_count;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Called at the start of a FETCH cycle; n cycles of expected state/strobes.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input int n,
                      input logic [0:4][2:0] st, input logic [0:4][10:0] sb, input bit retire);
      tag++;
      bus.opcode = op;
      bus.funct  = fn;
      for (int i = 0; i < n; i++) push(st[i], sb[i], 1'b0);
      cycles(n);
      if (retire) exp_count = exp_count + 32'd1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.opcode    = 6'h00;
      bus.funct     = 6'h20;
      bus.mem_ready = 1'b1;
      #50;
      chk("reset_state", 32'(bus.state), 32'd0);
      chk("reset_count", bus.instr_count, 32'd0);
      chk("reset_strobes", 32'(strobes()), 32'd0);
      chk("reset_fault", 32'(bus.fault), 32'd0);
      #49;
      reset = 1'b1;

      // add, jr, jal
      run(6'h00, 6'h20, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0}, {M_F, 11'h0, 11'h0, M_RW, 11'h0}, 1);
      run(6'h00, 6'h08, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0}, {M_F, 11'h0, M_JRN | M_PC, 11'h0, 11'h0}, 1);
      run(6'h03, 6'h00, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0},
          {M_F, 11'h0, M_JAL | M_PC | M_RW, 11'h0, 11'h0}, 1);
      chk("count_after_add_jr_jal", bus.instr_count, 32'd3);
      // illegal 0x3F, beq, bne, j
      run(6'h3F, 6'h00, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, {M_F, M_ILL, 11'h0, 11'h0, 11'h0}, 0);
      chk("count_after_illegal", bus.instr_count, 32'd3);
      run(6'h04, 6'h00, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0}, {M_F, 11'h0, M_BR, 11'h0, 11'h0}, 1);
      run(6'h05, 6'h00, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0}, {M_F, 11'h0, M_NBR, 11'h0, 11'h0}, 1);
      run(6'h02, 6'h00, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0}, {M_F, 11'h0, M_JMP | M_PC, 11'h0, 11'h0}, 1);
      // lw, sw, I-arith range edges, illegal neighbours
      run(6'h23, 6'h00, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, {M_F, 11'h0, 11'h0, M_MR, M_RW}, 1);
      run(6'h2B, 6'h00, 4, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0}, {M_F, 11'h0, 11'h0, M_MW, 11'h0}, 1);
      run(6'h08, 6'h3F, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0}, {M_F, 11'h0, 11'h0, M_RW, 11'h0}, 1);
      run(6'h0F, 6'h00, 4, {3'd0, 3'd1, 3'd2, 3'd4, 3'd0}, {M_F, 11'h0, 11'h0, M_RW, 11'h0}, 1);
      run(6'h01, 6'h00, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, {M_F, M_ILL, 11'h0, 11'h0, 11'h0}, 0);
      run(6'h10, 6'h00, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, {M_F, M_ILL, 11'h0, 11'h0, 11'h0}, 0);
      run(6'h06, 6'h00, 2, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}, {M_F, M_ILL, 11'h0, 11'h0, 11'h0}, 0);
      chk("count_mid", bus.instr_count, 32'd10);

`ifdef MULTICYCLE_MEM_WAIT_EN
      // lw with mem_ready low for 3 MEM cycles
      tag++;
      bus.opcode = 6'h23;
      push(3'd0, M_F, 1'b0);
      push(3'd1, 11'h0, 1'b0);
      push(3'd2, 11'h0, 1'b0);
      for (int i = 0; i < 4; i++) push(3'd3, M_MR, 1'b0);
      push(3'd4, M_RW, 1'b0);
      cycles(3);
      bus.mem_ready = 1'b0;
      cycles(3);
      bus.mem_ready = 1'b1;
      cycles(2);
      exp_count = exp_count + 32'd1;
      // FETCH never completes: 15 wait cycles then sticky FAULT
      tag++;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) push(3'd0, M_F, 1'b0);
      for (int i = 0; i < 4; i++) push(3'd7, 11'h0, 1'b1);
      cycles(19);
      chk("fault_sticky", 32'(bus.fault), 32'd1);
      bus.mem_ready = 1'b1;
`else
      // mem_ready ignored: zero-wait timing even with it low
      bus.mem_ready = 1'b0;
      run(6'h23, 6'h00, 5, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, {M_F, 11'h0, 11'h0, M_MR, M_RW}, 1);
      chk("fault_const", 32'(bus.fault), 32'd0);
      bus.mem_ready = 1'b1;
`endif

      // Asynchronous reset, then reset asserted in MEM of sw
      reset = 1'b0;
      #1;
      chk("rst2_state", 32'(bus.state), 32'd0);
      chk("rst2_fault", 32'(bus.fault), 32'd0);
      chk("rst2_count", bus.instr_count, 32'd0);
      exp_count = 0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      tag++;
      bus.opcode = 6'h2B;
      push(3'd0, M_F, 1'b0);
      push(3'd1, 11'h0, 1'b0);
      push(3'd2, 11'h0, 1'b0);
      cycles(3);
      chk("sw_mem_write_before", 32'(bus.mem_write), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("sw_mem_write_async_drop", 32'(bus.mem_write), 32'd0);
      chk("sw_reset_state", 32'(bus.state), 32'd0);
      chk("sw_reset_count", bus.instr_count, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      run(6'h2B, 6'h00, 4, {3'd0, 3'd1, 3'd2, 3'd3, 3'd0}, {M_F, 11'h0, 11'h0, M_MW, 11'h0}, 1);
      run(6'h04, 6'h00, 3, {3'd0, 3'd1, 3'd2, 3'd0, 3'd0}, {M_F, 11'h0, M_BR, 11'h0, 11'h0}, 1);
      chk("final_count", bus.instr_count, 32'd2);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
